// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Brief    : Shared encodings for the multiply/divide-unit controller.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  localparam int c_DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MFHI  = 3'd2,
    OP_MFLO  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FIX    = 2'd3
  } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/mdu_unsigned_fix.sv
`default_nettype none
// ============================================================================
// Module   : mdu_unsigned_fix
// Brief    : Turns a signed 2W-bit product into the unsigned product of the
//            same operand bit patterns (modulo 2^(2W)).
// Revision : 1.0 - initial release
// ============================================================================
module mdu_unsigned_fix
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH
) (
  input  logic [2*DATA_WIDTH-1:0] i_prod,
  input  logic [DATA_WIDTH-1:0]   i_op1,
  input  logic [DATA_WIDTH-1:0]   i_op2,
  output logic [2*DATA_WIDTH-1:0] o_fixed
);

  logic [2*DATA_WIDTH-1:0] w_add1;
  logic [2*DATA_WIDTH-1:0] w_add2;

  // A negative operand under signed reading lost 2^W times the other operand.
  always_comb begin
    w_add1  = i_op1[DATA_WIDTH-1] ? {i_op2, {DATA_WIDTH{1'b0}}} : '0;
    w_add2  = i_op2[DATA_WIDTH-1] ? {i_op1, {DATA_WIDTH{1'b0}}} : '0;
    o_fixed = i_prod + w_add1 + w_add2;
  end

endmodule
`default_nettype wire

// File: rtl/mdu_controller.sv
`default_nettype none
// ============================================================================
// Module   : mdu_controller
// Brief    : Sequences MULT/MULTU through the shared multiplier, owns HI/LO
//            and serves MFHI/MFLO/MTHI/MTLO; stalls the control FSM via busy.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_controller
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT    = 2*DATA_WIDTH+8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    cmd_valid,
  input  logic [2:0]              cmd_op,
  output logic                    cmd_ready,
  input  logic [DATA_WIDTH-1:0]   rs_data,
  input  logic [DATA_WIDTH-1:0]   rt_data,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    timeout_err,
  output logic                    mul_start,
  output logic [DATA_WIDTH-1:0]   mul_op1,
  output logic [DATA_WIDTH-1:0]   mul_op2,
  input  logic [2*DATA_WIDTH-1:0] mul_result,
  input  logic                    mul_valid
);

  localparam int c_CNT_W = $clog2(TIMEOUT+1);

  mdu_state_e              r_state;
  mdu_state_e              w_state_nxt;
  logic [c_CNT_W-1:0]      r_cnt;
  logic                    r_unsigned;
  logic [2*DATA_WIDTH-1:0] r_prod;
  logic [2*DATA_WIDTH-1:0] w_fixed;
  logic [DATA_WIDTH-1:0]   r_hi;
  logic [DATA_WIDTH-1:0]   r_lo;
  logic                    w_accept;
  logic                    w_is_mul;
  logic                    w_timeout;

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_is_mul  = (cmd_op == OP_MULT) || (cmd_op == OP_MULTU);
  // r_cnt holds the number of WAIT cycles already spent before this one.
  assign w_timeout = (r_cnt == c_CNT_W'(TIMEOUT-1));

  mdu_unsigned_fix #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fix (
    .i_prod  (r_prod),
    .i_op1   (mul_op1),
    .i_op2   (mul_op2),
    .o_fixed (w_fixed)
  );

  always_comb begin
    w_state_nxt = r_state;
    mul_start   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_mul) w_state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        mul_start   = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (mul_valid)      w_state_nxt = r_unsigned ? ST_FIX : ST_IDLE;
        else if (w_timeout) w_state_nxt = ST_IDLE;
      end
      ST_FIX: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_unsigned  <= 1'b0;
      r_prod      <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      mul_op1     <= '0;
      mul_op2     <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      rd_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (cmd_op)
              OP_MULT, OP_MULTU: begin
                mul_op1    <= rs_data;
                mul_op2    <= rt_data;
                r_unsigned <= (cmd_op == OP_MULTU);
              end
              OP_MFHI: begin
                rd_data  <= r_hi;
                rd_valid <= 1'b1;
              end
              OP_MFLO: begin
                rd_data  <= r_lo;
                rd_valid <= 1'b1;
              end
              OP_MTHI: r_hi <= rs_data;
              OP_MTLO: r_lo <= rs_data;
              default: ;
            endcase
          end
        end
        ST_LAUNCH: begin
          r_cnt <= '0;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + c_CNT_W'(1);
          // A product arriving on the last allowed cycle still wins.
          if (mul_valid) begin
            if (r_unsigned) r_prod <= mul_result;
            else            {r_hi, r_lo} <= mul_result;
          end else if (w_timeout) begin
            timeout_err <= 1'b1;
          end
        end
        ST_FIX: begin
          {r_hi, r_lo} <= w_fixed;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_controller
// Brief    : Directed bench for mdu_controller (W=5) with a latency-programmable
//            multiplier model and a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_controller;

  localparam int W  = 5;
  localparam int TO = 2*W+8;

  localparam logic [2:0] c_MULT  = 3'd0;
  localparam logic [2:0] c_MULTU = 3'd1;
  localparam logic [2:0] c_MFHI  = 3'd2;
  localparam logic [2:0] c_MFLO  = 3'd3;
  localparam logic [2:0] c_MTHI  = 3'd4;
  localparam logic [2:0] c_MTLO  = 3'd5;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic           cmd_valid = 1'b0;
  logic [2:0]     cmd_op = 3'd0;
  logic           cmd_ready;
  logic [W-1:0]   rs_data = '0;
  logic [W-1:0]   rt_data = '0;
  logic [W-1:0]   rd_data;
  logic           rd_valid;
  logic           busy;
  logic           timeout_err;
  logic           mul_start;
  logic [W-1:0]   mul_op1;
  logic [W-1:0]   mul_op2;
  logic [2*W-1:0] mul_result = '0;
  logic           mul_valid = 1'b0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  mdu_controller #(
    .DATA_WIDTH (W)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_ready   (cmd_ready),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .busy        (busy),
    .timeout_err (timeout_err),
    .mul_start   (mul_start),
    .mul_op1     (mul_op1),
    .mul_op2     (mul_op2),
    .mul_result  (mul_result),
    .mul_valid   (mul_valid)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] sprod(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return (2*W)'(sa * sb);
  endfunction

  function automatic logic [2*W-1:0] uprod(input logic [W-1:0] a, input logic [W-1:0] b);
    int ua, ub;
    ua = int'(a);
    ub = int'(b);
    return (2*W)'(ua * ub);
  endfunction

  // Multiplier model: valid pulses mul_lat cycles after the start cycle.
  int mul_lat   = 6;
  bit mul_never = 1'b0;
  initial begin
    bit             pend;
    bit             nxt;
    int             fire_at;
    logic [2*W-1:0] prod;
    pend = 1'b0;
    fire_at = 0;
    prod = '0;
    forever begin
      @(negedge CLK);
      nxt = 1'b0;
      if (mul_start === 1'b1 && !mul_never) begin
        pend    = 1'b1;
        fire_at = cyc + mul_lat;
        prod    = sprod(mul_op1, mul_op2);
      end
      if (pend && (cyc + 1 == fire_at)) begin
        nxt  = 1'b1;
        pend = 1'b0;
      end
      @(posedge CLK);
      #1;
      mul_valid = nxt;
      if (nxt) mul_result = prod;
    end
  end

  // Reference model: timeline of a command from its acceptance cycle.
  logic [W-1:0] m_hi, m_lo, m_op1, m_op2, m_rdd;
  bit m_rdv, m_busy, m_start, m_err, m_inflight, m_unsigned, m_fixpend, m_known;
  int m_age;
  initial begin
    m_known = 1'b0;
    forever begin
      @(negedge CLK);
      if (m_known) begin
        chk("busy",        32'(busy),        32'(m_busy));
        chk("cmd_ready",   32'(cmd_ready),   32'(!m_busy));
        chk("mul_start",   32'(mul_start),   32'(m_start));
        chk("rd_valid",    32'(rd_valid),    32'(m_rdv));
        chk("rd_data",     32'(rd_data),     32'(m_rdd));
        chk("timeout_err", 32'(timeout_err), 32'(m_err));
        chk("mul_op1",     32'(mul_op1),     32'(m_op1));
        chk("mul_op2",     32'(mul_op2),     32'(m_op2));
      end
      if (!RST) begin
        m_known = 1'b1;
        m_hi = '0; m_lo = '0; m_op1 = '0; m_op2 = '0; m_rdd = '0;
        m_rdv = 1'b0; m_busy = 1'b0; m_start = 1'b0; m_err = 1'b0;
        m_inflight = 1'b0; m_unsigned = 1'b0; m_fixpend = 1'b0; m_age = 0;
      end else if (m_known) begin
        m_rdv = 1'b0;
        if (!m_inflight) begin
          if (cmd_valid) begin
            case (cmd_op)
              c_MULT, c_MULTU: begin
                m_inflight = 1'b1;
                m_age      = 0;
                m_unsigned = (cmd_op == c_MULTU);
                m_op1      = rs_data;
                m_op2      = rt_data;
                m_fixpend  = 1'b0;
              end
              c_MFHI: begin m_rdd = m_hi; m_rdv = 1'b1; end
              c_MFLO: begin m_rdd = m_lo; m_rdv = 1'b1; end
              c_MTHI: m_hi = rs_data;
              c_MTLO: m_lo = rs_data;
              default: ;
            endcase
          end
        end else begin
          if (m_fixpend) begin
            {m_hi, m_lo} = uprod(m_op1, m_op2);
            m_inflight   = 1'b0;
          end else if (m_age >= 2 && mul_valid) begin
            if (m_unsigned) m_fixpend = 1'b1;
            else begin
              {m_hi, m_lo} = sprod(m_op1, m_op2);
              m_inflight   = 1'b0;
            end
          end else if (m_age == TO + 1) begin
            m_err      = 1'b1;
            m_inflight = 1'b0;
          end
        end
        m_age++;
        m_busy  = m_inflight;
        m_start = m_inflight && (m_age == 1);
      end
    end
  end

  // Drivers run at 1 time unit after a rising edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
    bit acc;
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    rs_data   = rs;
    rt_data   = rt;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge CLK);
      acc = (cmd_ready === 1'b1);
      n++;
      @(posedge CLK);
      #1;
    end
    cmd_valid = 1'b0;
    chk("cmd_accepted", 32'(acc), 32'd1);
  endtask

  task automatic read_chk(input logic [2:0] op, input logic [W-1:0] exp, input string name);
    issue(op, '0, '0);
    chk({name, "_valid"}, 32'(rd_valid), 32'd1);
    chk(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;

    read_chk(c_MFHI, 5'b00000, "reset_hi");
    read_chk(c_MFLO, 5'b00000, "reset_lo");

    issue(c_MULT, 5'b01011, 5'b01110);
    wait_idle();
    read_chk(c_MFHI, 5'b00100, "mult154_hi");
    read_chk(c_MFLO, 5'b11010, "mult154_lo");

    issue(c_MULTU, 5'b11111, 5'b11111);
    wait_idle();
    read_chk(c_MFHI, 5'b11110, "multu961_hi");
    read_chk(c_MFLO, 5'b00001, "multu961_lo");
    issue(c_MULT, 5'b11111, 5'b11111);
    wait_idle();
    read_chk(c_MFHI, 5'b00000, "mult_m1sq_hi");
    read_chk(c_MFLO, 5'b00001, "mult_m1sq_lo");

    issue(c_MULT, 5'b11111, 5'b00010);
    read_chk(c_MFLO, 5'b11110, "held_mflo");
    read_chk(c_MFHI, 5'b11111, "held_mfhi");

    mul_never = 1'b1;
    issue(c_MULT, 5'b00011, 5'b00011);
    wait_idle();
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    chk("timeout_ready", 32'(cmd_ready), 32'd1);
    read_chk(c_MFHI, 5'b11111, "timeout_keep_hi");
    read_chk(c_MFLO, 5'b11110, "timeout_keep_lo");
    mul_never = 1'b0;

    issue(c_MTHI, 5'b10101, '0);
    issue(c_MTLO, 5'b01010, '0);
    read_chk(c_MFHI, 5'b10101, "mthi_hi");
    read_chk(c_MFLO, 5'b01010, "mtlo_lo");

    issue(c_MULT, 5'b00101, 5'b00110);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(mul_start), 32'd0);
    chk("rst_op1", 32'(mul_op1), 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    repeat (10) @(posedge CLK);
    #1;
    read_chk(c_MFHI, 5'b00000, "post_rst_hi");
    read_chk(c_MFLO, 5'b00000, "post_rst_lo");
    issue(c_MULT, 5'b00010, 5'b00011);
    wait_idle();
    read_chk(c_MFLO, 5'b00110, "post_rst_mult_lo");
    read_chk(c_MFHI, 5'b00000, "post_rst_mult_hi");

    repeat (2) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
`default_nettype wire

// File: doc/mdu_controller.md
# mdu_controller

Sequencer for the shared `booth_multiplier` in the multi-cycle MIPS datapath. It accepts MULT, MULTU, MFHI, MFLO, MTHI and MTLO commands from the main control unit, launches and waits on the multiplier, and applies the unsigned fix-up for MULTU. It owns the architectural HI/LO registers and tells the control FSM to hold while a product is in flight.

## Interface
- `DATA_WIDTH`, 32: operand width. Benches use 5.
- `TIMEOUT`, 2*DATA_WIDTH+8: maximum WAIT cycles before abort.
- `CLK`  in  1: single clock. All logic is rising-edge.
- `RST`  in  1: reset. Synchronous, active-low.
- `cmd_valid`  in  1: a command is presented.
- `cmd_op`  in  3: opcode, encoded in `mdu_pkg`: MULT=0, MULTU=1, MFHI=2, MFLO=3, MTHI=4, MTLO=5. Values 6 and 7 are accepted as no-ops.
- `cmd_ready`  out  1: high only in IDLE.
- `rs_data`, `rt_data`  in  DATA_WIDTH: operands. MTHI and MTLO use `rs_data`.
- `rd_data`  out  DATA_WIDTH: registered HI or LO for MFHI/MFLO.
- `rd_valid`  out  1: one-cycle pulse in the cycle after an MFHI/MFLO is accepted.
- `busy`  out  1: high in any state other than IDLE. Used as the stall to the control FSM.
- `timeout_err`  out  1: sticky. Cleared only by reset.
- `mul_start`  out  1: one-cycle start pulse to the multiplier.
- `mul_op1`, `mul_op2`  out  DATA_WIDTH: multiplier operands.
- `mul_result`  in  2*DATA_WIDTH: signed product from the multiplier.
- `mul_valid`  in  1: product valid from the multiplier.

## Operation
- States are IDLE, LAUNCH, WAIT and FIX.
- A command is accepted when `cmd_valid && cmd_ready`.
- IDLE, on accepted MULT/MULTU:
  - Latch `rs_data` into `mul_op1` and `rt_data` into `mul_op2`.
  - Latch the unsigned flag.
  - Go to LAUNCH.
- IDLE, on accepted MFHI/MFLO: register HI or LO into `rd_data` and pulse `rd_valid` in the next cycle. No state change.
- IDLE, on accepted MTHI/MTLO: write `rs_data` into HI or LO. The write is visible in the next cycle.
- LAUNCH: drive `mul_start`=1 for exactly one cycle, clear the watchdog counter, go to WAIT.
- WAIT:
  - On `mul_valid`, signed: HI = result[2W-1:W], LO = result[W-1:0], go to IDLE.
  - On `mul_valid`, unsigned: capture the product and go to FIX.
- WAIT, counter reaches TIMEOUT: set `timeout_err`, leave HI/LO unchanged, go to IDLE.
- FIX: compute P' = P + (op1[W-1] ? op2<<W : 0) + (op2[W-1] ? op1<<W : 0), all modulo 2^(2W). Write HI/LO from P' and go to IDLE.
- `mul_op1`/`mul_op2` hold stable from LAUNCH until the controller leaves WAIT.
- `mul_valid` is ignored in IDLE, LAUNCH and FIX.
- Reset in any state, including mid-multiply:
  - State to IDLE.
  - HI=LO=0.
  - `mul_start`=0, `mul_op1`=`mul_op2`=0.
  - `rd_data`=0, `rd_valid`=0, `timeout_err`=0.
  - Any in-flight product is discarded.

## Timing
- MULT accepted at cycle N:
  - `busy` and `mul_start` are high in N+1.
  - If `mul_valid` arrives at cycle M, HI/LO are updated at the end of M and `busy` is low in M+1.
- MULTU adds one cycle: HI/LO are updated at the end of M+1 and `busy` is low in M+2.
- A command presented while `busy`=1 is not accepted. The issuer holds it until `cmd_ready` goes high.
- `mul_valid` in the same cycle the counter reaches TIMEOUT: valid wins and no error is raised.

## Structure
- `mdu_pkg` holds:
  - `cmd_op` encodings.
  - State encodings.
  - Default `DATA_WIDTH`.
- Sub-module `mdu_unsigned_fix`: combinational, 2W-bit fix-up adder used in FIX.
- `booth_multiplier` is a sibling instance in the datapath, not instantiated inside this block.

## Test plan
Use W=5 and a behavioural multiplier model with programmable latency (default 6 cycles).
- Reset released, then MFHI and MFLO -> `rd_data`=0 both times, one `rd_valid` pulse each, `busy`=0.
- MULT 01011 × 01110 -> `mul_start` pulses once, then HI=00100, LO=11010 (154). `busy` is high from N+1 through M.
- MULTU 11111 × 11111 -> HI=11110, LO=00001 (961), one cycle after `mul_valid`. MULT on the same operands -> HI=00000, LO=00001.
- MULT 11111 × 00010 with MFLO held on `cmd_valid` throughout -> MFLO is not accepted until `busy` falls, then returns LO=11110 (HI=11111).
- Model never asserts `mul_valid` -> after TIMEOUT WAIT cycles, `timeout_err`=1, HI/LO keep their old values, `cmd_ready`=1.
- MTHI 10101 then MTLO 01010 -> MFHI returns 10101 and MFLO returns 01010. Assert `RST`=0 mid-MULT -> all outputs are 0 in the next cycle and a late `mul_valid` is ignored.
